// File: rtl/arb_client_if.sv
// Handshake and data bundle between a local packet source, the arbiter and
// the switch-side consumer of an arb_client.
interface arb_client_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_last;
    logic          in_ready;
    logic          req;
    logic          ack;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;

    // Block side: consumes the packet and the grant, drives request and output words.
    modport slave (
        input  din, din_valid, din_last, ack,
        output in_ready, req, dout, dout_valid, dout_last
    );

    // Environment side: source, arbiter and switch.
    modport master (
        output din, din_valid, din_last, ack,
        input  in_ready, req, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/arb_client.sv
// arb_client: buffers one packet of up to DEPTH words from a local source,
// requests a round-robin arbiter, and streams the packet out one word per
// granted cycle. After every packet it drops req for one GAP cycle so the
// arbiter sees the falling edge and rotates priority. DEPTH must be 2..16.
module arb_client #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    arb_client_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] wcnt_r, wcnt_s;
    logic [CW-1:0] rcnt_r, rcnt_s;
    logic [CW-1:0] len_r, len_s;
    logic          req_r, req_s;
    logic          in_ready_r, in_ready_s;
    logic [DW-1:0] dout_r, dout_s;
    logic          dout_valid_r, dout_valid_s;
    logic          dout_last_r, dout_last_s;
    logic          wr_en_s;
    logic [CW-1:0] wcnt_inc_s;
    logic [DW-1:0] buf_r [DEPTH];

    assign wcnt_inc_s = wcnt_r + CNT_ONE;

    // State register; reset returns to FILL so any buffered packet is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode for the packet FSM.
    always_comb begin
        state_s      = state_r;
        wcnt_s       = wcnt_r;
        rcnt_s       = rcnt_r;
        len_s        = len_r;
        req_s        = req_r;
        dout_s       = dout_r;
        dout_valid_s = 1'b0;
        dout_last_s  = 1'b0;
        wr_en_s      = 1'b0;
        case (state_r)
            S_FILL: begin
                if (bus.din_valid) begin
                    wr_en_s = 1'b1;
                    wcnt_s  = wcnt_inc_s;
                    // A full buffer ends the packet even without din_last.
                    if (bus.din_last || (wcnt_inc_s == CNT_DEPTH)) begin
                        len_s   = wcnt_inc_s;
                        req_s   = 1'b1;
                        state_s = S_REQ;
                    end else begin
                        state_s = S_FILL;
                    end
                end else begin
                    state_s = S_FILL;
                end
            end
            S_REQ: begin
                if (bus.ack) begin
                    dout_s       = buf_r[0];
                    dout_valid_s = 1'b1;
                    rcnt_s       = CNT_ONE;
                    if (len_r == CNT_ONE) begin
                        dout_last_s = 1'b1;
                        req_s       = 1'b0;
                        state_s     = S_GAP;
                    end else begin
                        state_s = S_XFER;
                    end
                end else begin
                    state_s = S_REQ;
                end
            end
            S_XFER: begin
                if (bus.ack) begin
                    dout_s       = buf_r[rcnt_r[IW-1:0]];
                    dout_valid_s = 1'b1;
                    rcnt_s       = rcnt_r + CNT_ONE;
                    if (rcnt_r == (len_r - CNT_ONE)) begin
                        dout_last_s = 1'b1;
                        req_s       = 1'b0;
                        state_s     = S_GAP;
                    end else begin
                        state_s = S_XFER;
                    end
                end else begin
                    // Grant paused: hold position, keep requesting.
                    state_s = S_XFER;
                end
            end
            S_GAP: begin
                wcnt_s  = CNT_ZERO;
                rcnt_s  = CNT_ZERO;
                state_s = S_FILL;
            end
            default: begin
                wcnt_s  = CNT_ZERO;
                rcnt_s  = CNT_ZERO;
                req_s   = 1'b0;
                state_s = S_FILL;
            end
        endcase
        in_ready_s = (state_s == S_FILL);
    end

    // Counters, request and output word registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_r       <= CNT_ZERO;
            rcnt_r       <= CNT_ZERO;
            len_r        <= CNT_ZERO;
            req_r        <= 1'b0;
            in_ready_r   <= 1'b1;
            dout_r       <= {DW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
        end else begin
            wcnt_r       <= wcnt_s;
            rcnt_r       <= rcnt_s;
            len_r        <= len_s;
            req_r        <= req_s;
            in_ready_r   <= in_ready_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            dout_last_r  <= dout_last_s;
        end
    end

    // Packet buffer, written at the fill pointer while accepting words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= {DW{1'b0}};
            end
        end else if (wr_en_s) begin
            buf_r[wcnt_r[IW-1:0]] <= bus.din;
        end else begin
            buf_r <= buf_r;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.req        = req_r;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout_last  = dout_last_r;
endmodule
